// File: rtl/soft_reset_gen.sv
// Downstream active-low reset generator: async assert, sync release after a programmable hold,
// plus soft-reset requests with a completion ACK. Optional retrigger: SOFT_RESET_GEN_RETRIGGER_EN.
module soft_reset_gen #(
  parameter int RSTDELAY = 4,
  parameter int CNT_W    = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ,
  output logic OUT_RST_N,
  output logic BUSY,
  output logic ACK
);

  typedef enum logic {HOLD = 1'b0, IDLE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(RSTDELAY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s0;
  logic             s1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= HOLD;
      cnt       <= '0;
      OUT_RST_N <= 1'b0;
      BUSY      <= 1'b1;
      ACK       <= 1'b0;
      s0        <= 1'b0;
      s1        <= 1'b0;
    end else begin
      s0  <= 1'b1;
      s1  <= s0;
      ACK <= 1'b0;
      case (state)
        HOLD: begin
          // Counting waits until the release synchronizer has filled.
          if (s1) begin
`ifdef SOFT_RESET_GEN_RETRIGGER_EN
            if (REQ) begin
              cnt <= '0;
            end else if (cnt == LAST) begin
`else
            if (cnt == LAST) begin
`endif
              state     <= IDLE;
              OUT_RST_N <= 1'b1;
              BUSY      <= 1'b0;
              ACK       <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        IDLE: begin
          if (REQ) begin
            state     <= HOLD;
            OUT_RST_N <= 1'b0;
            BUSY      <= 1'b1;
            cnt       <= '0;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: doc/soft_reset_gen.md
# soft_reset_gen

Reset generator that drives an active-low reset to downstream logic. It is the issuing end of the reset path whose consumers pass `OUT_RST_N`-style resets through unchanged. The block asserts `OUT_RST_N` asynchronously on the local reset and releases it synchronously to `CLK` after a programmable hold. It also lets a local controller request a soft reset pulse of fixed length and get a completion acknowledge.

## Interface
- `RSTDELAY`, default 4: number of `CLK` cycles `OUT_RST_N` is held low after counting starts; legal range ≥1.
- `CNT_W`, default 8: hold-counter width; 2^`CNT_W` must exceed `RSTDELAY`.

- `CLK`  in  1  sole clock; all state is on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `REQ`  in  1  soft-reset request, sampled on the rising edge.
- `OUT_RST_N`  out  1  downstream reset, active-low, registered.
- `BUSY`  out  1  high while in HOLD; registered, always equals ~`OUT_RST_N`.
- `ACK`  out  1  one-cycle pulse marking reset release, registered.

## Operation
- **States:** HOLD (`OUT_RST_N`=0, `BUSY`=1) and IDLE (`OUT_RST_N`=1, `BUSY`=0).
- **Release synchronizer:** 2-flop chain `s0`→`s1`.
  - Both flops clear asynchronously on `RST`.
  - `s0` shifts in 1 each edge; `s1` follows `s0`.
  - Counting is enabled only when `s1`=1.
- **Reset values on `RST` (immediate, asynchronous):** state=HOLD, `cnt`=0, `OUT_RST_N`=0, `BUSY`=1, `ACK`=0, `s0`=`s1`=0.
- **HOLD with `s1`=1:**
  - If `cnt`==`RSTDELAY`-1: go to IDLE, set `OUT_RST_N`=1, `BUSY`=0, `ACK`=1, `cnt`=0.
  - Otherwise: `cnt`+=1.
- **HOLD with `s1`=0:** `cnt` holds.
- **IDLE with `REQ`=1:** go to HOLD, `OUT_RST_N`=0, `BUSY`=1, `cnt`=0.
- **IDLE with `REQ`=0:** no change.
- **`ACK`:** 1 only in the cycle after the HOLD→IDLE edge; 0 otherwise. It pulses for both `RST`-initiated and `REQ`-initiated releases.
- **`REQ` in the `ACK` cycle:** the state is already IDLE, so the request is accepted and the block re-enters HOLD at the next edge.
- **`REQ` during HOLD:** see Configuration.
- **`RST` during HOLD or IDLE:** immediate return to HOLD and the synchronizer clears. Any pending release is cancelled, and no `ACK` is issued for the aborted hold.
- **Counter:** unsigned, `CNT_W` bits, never wraps because it clears at `RSTDELAY`-1.

## Timing
- **`RST` assertion:** `OUT_RST_N` goes to 0 with no clock required.
- **`RST` deassertion before edge e1:**
  - e1: `s0`=1.
  - e2: `s1`=1.
  - Counting runs from e3.
  - `OUT_RST_N` rises after edge e(2+`RSTDELAY`); with `RSTDELAY`=4 that is e6.
  - `ACK` is high in the cycle following that edge.
- **`REQ` sampled at edge e0 in IDLE:**
  - `OUT_RST_N`=0 after e0.
  - Release occurs at e(`RSTDELAY`), so `OUT_RST_N` is low for exactly `RSTDELAY` cycles.
  - `ACK` is high in the cycle after e(`RSTDELAY`).
- **Minimum high time of `OUT_RST_N`** between back-to-back `REQ`s: 1 cycle.

## Configuration
- **Macro:** `SOFT_RESET_GEN_RETRIGGER_EN`.
- **Defined:** `REQ`=1 in HOLD with `s1`=1 reloads `cnt`=0. The hold extends so release occurs `RSTDELAY` edges after the last sampled `REQ`.
- **Undefined:** `REQ` in HOLD is ignored and release timing is unaffected.

## Test plan
1. `RSTDELAY`=4. Hold `RST`=1 for 3 cycles, then deassert. -> `OUT_RST_N`=0 and `BUSY`=1 throughout; `OUT_RST_N` rises after edge 6 post-deassert; `ACK`=1 for exactly one cycle after edge 6.
2. From IDLE, 1-cycle `REQ` at e0. -> `OUT_RST_N`=0 over e0..e4 (4 cycles), high after e4; `ACK` pulse after e4; `BUSY` = ~`OUT_RST_N` every cycle.
3. `REQ` at e0, then again at e2. -> Without macro: release at e4, single `ACK`. With `SOFT_RESET_GEN_RETRIGGER_EN`: release at e6, single `ACK`.
4. `REQ` held high continuously from IDLE. -> `OUT_RST_N` pattern 0,0,0,0,1 repeating; `ACK` high during each 1-cycle IDLE window.
5. `REQ` at e0, `RST` pulse between e2 and e3. -> `OUT_RST_N` stays 0 with no `ACK` from the aborted hold; release after edge 6 post-`RST`-deassert with one `ACK`.
6. `RSTDELAY`=1, `CNT_W`=1. -> After reset, release after e3; a `REQ` at e0 gives exactly one low cycle; the counter never exceeds 0.
